// File: rtl/airlock_pkg.sv
// Shared state encoding and default sizing for the airlock chamber controller.
package airlock_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUMP_DOWN = 3'd1,
        VENT_UP   = 3'd2,
        FAULT     = 3'd3,
        PAUSED    = 3'd4
    } airlock_state_e;

    localparam int unsigned DEF_LEVEL_W     = 4;
    localparam int unsigned DEF_MAX_LEVEL   = 10;
    localparam int unsigned DEF_STEP_CYCLES = 3;

    // A single-cycle step still needs a one-bit counter to hold a value.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/airlock_step_timer.sv
// Step prescaler: counts 0..STEP_CYCLES-1 while enabled and not held,
// pulsing o_step on the cycle whose edge wraps the count.
module airlock_step_timer
    import airlock_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_hold,
    input  logic i_enable,
    output logic o_step
);

    localparam int unsigned      CNT_W = timer_width(STEP_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_step = i_enable & ~i_hold & ~i_clear & w_wrap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !i_hold) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/airlock_chamber_ctrl.sv
// Airlock chamber controller: evacuation/pressurization sequencing with door interlock.
// Build option AIRLOCK_PAUSE_RESUME_EN turns a mid-operation door opening into a resumable pause.
module airlock_chamber_ctrl
    import airlock_pkg::*;
#(
    parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
    parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               begin_Evacuation,
    input  logic               begin_Pressurization,
    input  logic               InnerClosed,
    input  logic               OuterClosed,
    input  logic               clear_Fault,
    output logic               Evacuated,
    output logic               Pressurized,
    output logic               PumpOn,
    output logic               VentOpen,
    output logic               Busy,
    output logic               Fault,
    output logic               Reject,
    output logic [LEVEL_W-1:0] Level
);

    localparam logic [LEVEL_W-1:0] L_FULL = LEVEL_W'(MAX_LEVEL);

    airlock_state_e     r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_reject;
`ifdef AIRLOCK_PAUSE_RESUME_EN
    airlock_state_e     r_resume;
`endif

    logic               w_doors_ok;
    logic               w_pumping;
    logic               w_clear;
    logic               w_hold;
    logic               w_step;
    logic               w_both_req;
    logic [LEVEL_W-1:0] w_next_level;
    logic [LEVEL_W-1:0] w_target;

    function automatic logic [LEVEL_W-1:0] sat_step(input logic [LEVEL_W-1:0] lvl,
                                                    input logic               up);
        if (up) begin
            return (lvl >= L_FULL) ? L_FULL : lvl + LEVEL_W'(1);
        end
        return (lvl == '0) ? '0 : lvl - LEVEL_W'(1);
    endfunction

    assign w_doors_ok   = InnerClosed & OuterClosed;
    assign w_both_req   = begin_Evacuation & begin_Pressurization;
    assign w_pumping    = (r_state == PUMP_DOWN) || (r_state == VENT_UP);
    assign w_clear      = (r_state == IDLE);
    assign w_next_level = sat_step(r_level, r_state == VENT_UP);
    assign w_target     = (r_state == VENT_UP) ? L_FULL : '0;

`ifdef AIRLOCK_PAUSE_RESUME_EN
    // The cycle that sees the door open still counts as pumped time.
    assign w_hold = 1'b0;
`else
    // A door opening on a wrap edge must not move the level.
    assign w_hold = ~w_doors_ok;
`endif

    airlock_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_clear (w_clear),
        .i_hold  (w_hold),
        .i_enable(w_pumping),
        .o_step  (w_step)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_level  <= L_FULL;
            r_reject <= 1'b0;
`ifdef AIRLOCK_PAUSE_RESUME_EN
            r_resume <= IDLE;
`endif
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_both_req) begin
                        r_reject <= 1'b1;
                    end else if (begin_Evacuation && r_level != '0) begin
                        if (w_doors_ok) r_state <= PUMP_DOWN;
                        else            r_reject <= 1'b1;
                    end else if (begin_Pressurization && r_level != L_FULL) begin
                        if (w_doors_ok) r_state <= VENT_UP;
                        else            r_reject <= 1'b1;
                    end
                end
                PUMP_DOWN, VENT_UP: begin
`ifdef AIRLOCK_PAUSE_RESUME_EN
                    if (w_step) begin
                        r_level <= w_next_level;
                    end
                    if (w_step && w_next_level == w_target) begin
                        r_state <= IDLE;
                    end else if (!w_doors_ok) begin
                        r_resume <= r_state;
                        r_state  <= PAUSED;
                    end
`else
                    if (!w_doors_ok) begin
                        r_state <= FAULT;
                    end else if (w_step) begin
                        r_level <= w_next_level;
                        if (w_next_level == w_target) r_state <= IDLE;
                    end
`endif
                end
                FAULT: begin
                    if (clear_Fault) r_state <= IDLE;
                end
`ifdef AIRLOCK_PAUSE_RESUME_EN
                PAUSED: begin
                    if (w_both_req)       r_state <= FAULT;
                    else if (clear_Fault) r_state <= IDLE;
                    else if (w_doors_ok)  r_state <= r_resume;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign PumpOn      = (r_state == PUMP_DOWN);
    assign VentOpen    = (r_state == VENT_UP);
`ifdef AIRLOCK_PAUSE_RESUME_EN
    assign Busy        = PumpOn | VentOpen | (r_state == PAUSED);
`else
    assign Busy        = PumpOn | VentOpen;
`endif
    assign Fault       = (r_state == FAULT);
    assign Evacuated   = (r_state == IDLE) && (r_level == '0);
    assign Pressurized = (r_state == IDLE) && (r_level == L_FULL);
    assign Reject      = r_reject;
    assign Level       = r_level;

endmodule

// File: tb/tb_airlock_chamber_ctrl.sv
// Directed bench for airlock_chamber_ctrl with MAX_LEVEL=4, STEP_CYCLES=2.
module tb_airlock_chamber_ctrl;

    logic       Clock;
    logic       Reset;
    logic       begin_Evacuation;
    logic       begin_Pressurization;
    logic       InnerClosed;
    logic       OuterClosed;
    logic       clear_Fault;
    logic       Evacuated;
    logic       Pressurized;
    logic       PumpOn;
    logic       VentOpen;
    logic       Busy;
    logic       Fault;
    logic       Reject;
    logic [3:0] Level;

    int n_checks = 0;
    int n_errors = 0;

    airlock_chamber_ctrl #(
        .LEVEL_W    (4),
        .MAX_LEVEL  (4),
        .STEP_CYCLES(2)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .begin_Evacuation    (begin_Evacuation),
        .begin_Pressurization(begin_Pressurization),
        .InnerClosed         (InnerClosed),
        .OuterClosed         (OuterClosed),
        .clear_Fault         (clear_Fault),
        .Evacuated           (Evacuated),
        .Pressurized         (Pressurized),
        .PumpOn              (PumpOn),
        .VentOpen            (VentOpen),
        .Busy                (Busy),
        .Fault               (Fault),
        .Reject              (Reject),
        .Level               (Level)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset                = 1'b0;
        begin_Evacuation     = 1'b0;
        begin_Pressurization = 1'b0;
        InnerClosed          = 1'b1;
        OuterClosed          = 1'b1;
        clear_Fault          = 1'b0;

        // Reset state
        tick();
        tick();
        chkl("rst_level", Level, 4'd4);
        chk1("rst_press", Pressurized, 1'b1);
        chk1("rst_evac", Evacuated, 1'b0);
        chk1("rst_pump", PumpOn, 1'b0);
        chk1("rst_vent", VentOpen, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_fault", Fault, 1'b0);
        chk1("rst_reject", Reject, 1'b0);
        Reset = 1'b1;
        tick();
        chk1("idle_press", Pressurized, 1'b1);

        // Full evacuation: 8 pump cycles, level 4,4,3,3,2,2,1,1 then 0
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("evac_pump", PumpOn, 1'b1);
            chk1("evac_busy", Busy, 1'b1);
            chkl("evac_level", Level, 4'(4 - i / 2));
            tick();
        end
        chk1("evac_pump_off", PumpOn, 1'b0);
        chk1("evac_done", Evacuated, 1'b1);
        chk1("evac_busy_off", Busy, 1'b0);
        chkl("evac_level0", Level, 4'd0);

        // Full pressurization from level 0
        begin_Pressurization = 1'b1;
        tick();
        begin_Pressurization = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("vent_open", VentOpen, 1'b1);
            chkl("vent_level", Level, 4'(i / 2));
            tick();
        end
        chk1("vent_off", VentOpen, 1'b0);
        chk1("vent_done", Pressurized, 1'b1);
        chkl("vent_level4", Level, 4'd4);

        // Already-satisfied request is a silent no-op
        begin_Pressurization = 1'b1;
        tick();
        begin_Pressurization = 1'b0;
        chk1("noop_reject", Reject, 1'b0);
        chk1("noop_busy", Busy, 1'b0);
        tick();
        chk1("noop_reject2", Reject, 1'b0);
        chk1("noop_press", Pressurized, 1'b1);

        // Refusals: door open, then both requests
        OuterClosed      = 1'b0;
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        OuterClosed      = 1'b1;
        chk1("rej_door", Reject, 1'b1);
        chk1("rej_door_busy", Busy, 1'b0);
        tick();
        chk1("rej_door_pulse", Reject, 1'b0);
        begin_Evacuation     = 1'b1;
        begin_Pressurization = 1'b1;
        tick();
        begin_Evacuation     = 1'b0;
        begin_Pressurization = 1'b0;
        chk1("rej_both", Reject, 1'b1);
        chk1("rej_both_busy", Busy, 1'b0);
        tick();
        chk1("rej_both_pulse", Reject, 1'b0);
        chkl("rej_level", Level, 4'd4);

        // Door opens mid-evacuation at level 2
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        repeat (4) tick();
        chkl("mid_level2", Level, 4'd2);
        chk1("mid_pump", PumpOn, 1'b1);
        InnerClosed = 1'b0;
        tick();
`ifdef AIRLOCK_PAUSE_RESUME_EN
        chk1("pause_busy", Busy, 1'b1);
        chk1("pause_fault", Fault, 1'b0);
        chk1("pause_pump", PumpOn, 1'b0);
        chkl("pause_level", Level, 4'd2);
        tick();
        chkl("pause_hold", Level, 4'd2);
        chk1("pause_busy2", Busy, 1'b1);
        InnerClosed = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("resume_pump", PumpOn, 1'b1);
            tick();
        end
        chk1("resume_pump_off", PumpOn, 1'b0);
        chk1("resume_evac", Evacuated, 1'b1);
        chkl("resume_level0", Level, 4'd0);
`else
        chk1("fault_set", Fault, 1'b1);
        chk1("fault_pump", PumpOn, 1'b0);
        chk1("fault_busy", Busy, 1'b0);
        chkl("fault_level", Level, 4'd2);
        tick();
        chkl("fault_hold", Level, 4'd2);
        chk1("fault_latched", Fault, 1'b1);
        InnerClosed      = 1'b1;
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        chk1("fault_ignore_req", Fault, 1'b1);
        chk1("fault_ignore_rej", Reject, 1'b0);
        chk1("fault_ignore_pump", PumpOn, 1'b0);
        clear_Fault = 1'b1;
        tick();
        clear_Fault = 1'b0;
        chk1("clear_fault", Fault, 1'b0);
        chkl("clear_level", Level, 4'd2);
        chk1("clear_evac", Evacuated, 1'b0);
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("rest_pump", PumpOn, 1'b1);
            tick();
        end
        chk1("rest_pump_off", PumpOn, 1'b0);
        chk1("rest_evac", Evacuated, 1'b1);
        chkl("rest_level0", Level, 4'd0);
`endif

        // Reset mid-vent
        begin_Pressurization = 1'b1;
        tick();
        begin_Pressurization = 1'b0;
        tick();
        tick();
        chk1("rv_vent", VentOpen, 1'b1);
        chkl("rv_level1", Level, 4'd1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chkl("rv_level", Level, 4'd4);
        chk1("rv_vent_off", VentOpen, 1'b0);
        chk1("rv_busy", Busy, 1'b0);
        chk1("rv_press", Pressurized, 1'b1);

        // Reset mid-pump
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        repeat (3) tick();
        chkl("rp_level3", Level, 4'd3);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chkl("rp_level", Level, 4'd4);
        chk1("rp_pump_off", PumpOn, 1'b0);

        // Door opens on the same edge as a prescaler wrap
        begin_Evacuation = 1'b1;
        tick();
        begin_Evacuation = 1'b0;
        tick();
        InnerClosed = 1'b0;
        tick();
`ifdef AIRLOCK_PAUSE_RESUME_EN
        chk1("wrap_busy", Busy, 1'b1);
        chk1("wrap_fault", Fault, 1'b0);
        chkl("wrap_level", Level, 4'd3);
`else
        chk1("wrap_fault", Fault, 1'b1);
        chk1("wrap_pump", PumpOn, 1'b0);
        chkl("wrap_level", Level, 4'd4);
`endif
        clear_Fault = 1'b1;
        tick();
        clear_Fault = 1'b0;
        InnerClosed = 1'b1;
        chk1("wrap_clr_fault", Fault, 1'b0);
        chk1("wrap_clr_busy", Busy, 1'b0);
`ifdef AIRLOCK_PAUSE_RESUME_EN
        chkl("wrap_clr_level", Level, 4'd3);
        chk1("wrap_clr_press", Pressurized, 1'b0);
`else
        chkl("wrap_clr_level", Level, 4'd4);
        chk1("wrap_clr_press", Pressurized, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
